// File: rtl/apb_req_queue.sv
// apb_req_queue
//   Command queue and sequencer in front of the APB bridge. Producer commands
//   are buffered in a DEPTH-entry FIFO and issued one at a time on the bridge
//   M-side request interface (MREQ/MREADY). Each completion is latched into a
//   response register that the producer must acknowledge (RSP_READY) before
//   the next command is issued.
//
// Ports
//   PCLK, PRESET            clock, synchronous active-high reset
//   CMD_*                   producer command channel (valid/ready)
//   RSP_*                   completion channel (valid/ready, rdata, slverr)
//   FILL_LEVEL              FIFO occupancy
//   MREQ, M*                request to bridge, fields from FIFO head
//   MREADY, MRDATA, MSLVERR bridge completion
//
// Option
//   APB_REQ_ERRCNT_EN       adds ERR_CNT (saturating slave-error count) and
//                           ERR_CLR (synchronous clear, wins over increment)
module apb_req_queue #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STROBE_WIDTH = DATA_WIDTH/8,
  parameter int PROT_WIDTH   = 3,
  parameter int DEPTH        = 4
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      CMD_VALID,
  output logic                      CMD_READY,
  input  logic [ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]     CMD_WDATA,
  input  logic [STROBE_WIDTH-1:0]   CMD_STRB,
  input  logic                      CMD_WRITE,
  input  logic [PROT_WIDTH-1:0]     CMD_PROT,
  output logic                      RSP_VALID,
  input  logic                      RSP_READY,
  output logic [DATA_WIDTH-1:0]     RSP_RDATA,
  output logic                      RSP_SLVERR,
  output logic [$clog2(DEPTH):0]    FILL_LEVEL,
  output logic                      MREQ,
  output logic [ADDR_WIDTH-1:0]     MADDR,
  output logic [DATA_WIDTH-1:0]     MWDATA,
  output logic [STROBE_WIDTH-1:0]   MSTRB,
  output logic                      MWRITE,
  output logic [PROT_WIDTH-1:0]     MPROT,
  input  logic                      MREADY,
  input  logic [DATA_WIDTH-1:0]     MRDATA,
  input  logic                      MSLVERR
`ifdef APB_REQ_ERRCNT_EN
  ,
  input  logic                      ERR_CLR,
  output logic [15:0]               ERR_CNT
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [STROBE_WIDTH-1:0] strb;
    logic                    write;
    logic [PROT_WIDTH-1:0]   prot;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wptr, rptr;
  logic          empty, full, push, pop, issue;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic          rsp_slverr;

  // FIFO bookkeeping: extra pointer MSB distinguishes full from empty
  assign empty      = (wptr == rptr);
  assign full       = (wptr[PW-1] != rptr[PW-1]) && (wptr[PW-2:0] == rptr[PW-2:0]);
  assign CMD_READY  = !full;
  assign push       = CMD_VALID && !full;
  assign issue      = (state == S_ISSUE);
  assign pop        = issue && MREADY;
  assign FILL_LEVEL = wptr - rptr;
  assign head       = mem[rptr[PW-2:0]];

  // Storage carries no reset; only the pointers define validity
  always_ff @(posedge PCLK) begin
    if (push) mem[wptr[PW-2:0]] <= '{CMD_ADDR, CMD_WDATA, CMD_STRB, CMD_WRITE, CMD_PROT};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_ISSUE;
      S_ISSUE: if (MREADY) state_nxt = S_RESP;
      // A command pushed on the acknowledge edge counts as queued
      S_RESP:  if (RSP_READY) state_nxt = (!empty || push) ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response register: loaded only at a completion, held through RESP
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else if (pop) begin
      rsp_rdata  <= head.write ? '0 : MRDATA;
      rsp_slverr <= MSLVERR;
    end
  end

  assign RSP_VALID  = (state == S_RESP);
  assign RSP_RDATA  = rsp_rdata;
  assign RSP_SLVERR = rsp_slverr;

  // Request fields come straight from the head; head is stable until pop
  assign MREQ   = issue;
  assign MADDR  = issue ? head.addr  : '0;
  assign MWDATA = issue ? head.wdata : '0;
  assign MSTRB  = issue ? head.strb  : '0;
  assign MWRITE = issue ? head.write : 1'b0;
  assign MPROT  = issue ? head.prot  : '0;

`ifdef APB_REQ_ERRCNT_EN
  always_ff @(posedge PCLK) begin
    if (PRESET)                                  ERR_CNT <= '0;
    else if (ERR_CLR)                            ERR_CNT <= '0;
    else if (pop && MSLVERR && ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_apb_req_queue.sv
module tb_apb_req_queue;
  localparam int AW = 32, DW = 32, SW = 4, PRW = 3, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic PRESET, CMD_VALID, CMD_READY, CMD_WRITE, RSP_VALID, RSP_READY, RSP_SLVERR;
  logic [AW-1:0] CMD_ADDR, MADDR;
  logic [DW-1:0] CMD_WDATA, RSP_RDATA, MWDATA, MRDATA;
  logic [SW-1:0] CMD_STRB, MSTRB;
  logic [PRW-1:0] CMD_PROT, MPROT;
  logic [$clog2(DEPTH):0] FILL_LEVEL;
  logic MREQ, MWRITE, MREADY, MSLVERR;
  logic ERR_CLR;
  logic [15:0] ERR_CNT;

  apb_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW),
                  .PROT_WIDTH(PRW), .DEPTH(DEPTH)) dut (
    .PCLK(clk), .PRESET(PRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR),
    .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB), .CMD_WRITE(CMD_WRITE),
    .CMD_PROT(CMD_PROT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_SLVERR(RSP_SLVERR), .FILL_LEVEL(FILL_LEVEL),
    .MREQ(MREQ), .MADDR(MADDR), .MWDATA(MWDATA), .MSTRB(MSTRB),
    .MWRITE(MWRITE), .MPROT(MPROT), .MREADY(MREADY), .MRDATA(MRDATA),
    .MSLVERR(MSLVERR)
`ifdef APB_REQ_ERRCNT_EN
    , .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT)
`endif
  );

`ifndef APB_REQ_ERRCNT_EN
  assign ERR_CNT = 16'd0;
`endif

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] strb;
    logic wr; logic [PRW-1:0] prot;
  } mcmd_t;

  mcmd_t q[$];
  bit m_busy = 0;      // a request is outstanding on the bridge
  bit m_rsp  = 0;      // a completion is waiting for the producer
  logic [DW-1:0] m_rdata = '0;
  logic m_slverr = 1'b0;
  logic [15:0] m_cnt = '0;
  bit m_push, m_cpl;

  always @(posedge clk) begin
    if (PRESET) begin
      q.delete(); m_busy = 0; m_rsp = 0; m_rdata = '0; m_slverr = 0; m_cnt = '0;
    end else begin
      m_push = CMD_VALID && (q.size() < DEPTH);
      m_cpl  = 0;
      if (m_busy) begin
        if (MREADY) begin
          m_cpl = 1;
          m_rdata = q[0].wr ? '0 : MRDATA;
          m_slverr = MSLVERR;
          void'(q.pop_front());
          m_busy = 0; m_rsp = 1;
        end
      end else if (m_rsp) begin
        if (RSP_READY) begin
          m_rsp = 0;
          m_busy = (q.size() > 0) || m_push;
        end
      end else if (q.size() > 0) begin
        m_busy = 1;
      end
      if (m_push) q.push_back('{CMD_ADDR, CMD_WDATA, CMD_STRB, CMD_WRITE, CMD_PROT});
`ifdef APB_REQ_ERRCNT_EN
      if (ERR_CLR) m_cnt = '0;
      else if (m_cpl && MSLVERR && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", CMD_READY, q.size() < DEPTH);
      chk("fill", FILL_LEVEL, q.size());
      chk("mreq", MREQ, m_busy);
      chk("maddr",  MADDR,  m_busy ? q[0].addr  : '0);
      chk("mwdata", MWDATA, m_busy ? q[0].wdata : '0);
      chk("mstrb",  MSTRB,  m_busy ? q[0].strb  : '0);
      chk("mwrite", MWRITE, m_busy ? q[0].wr    : 1'b0);
      chk("mprot",  MPROT,  m_busy ? q[0].prot  : '0);
      chk("rsp_valid", RSP_VALID, m_rsp);
      chk("rsp_rdata", RSP_RDATA, m_rdata);
      chk("rsp_slverr", RSP_SLVERR, m_slverr);
      chk("err_cnt", ERR_CNT, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cmd(input logic [AW-1:0] a, input logic w);
    CMD_VALID = 1; CMD_ADDR = a; CMD_WRITE = w;
    CMD_WDATA = $urandom; CMD_STRB = SW'($urandom); CMD_PROT = PRW'($urandom);
  endtask

  task automatic xfer(input logic [AW-1:0] a, input logic e, input logic clr);
    cmd(a, 1'b0); nxt();
    CMD_VALID = 0; nxt();
    MREADY = 1; MSLVERR = e; ERR_CLR = clr; MRDATA = $urandom; nxt();
    MREADY = 0; MSLVERR = 0; ERR_CLR = 0; RSP_READY = 1; nxt();
    RSP_READY = 0;
  endtask

  initial begin
    PRESET = 1; CMD_VALID = 0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_STRB = '0;
    CMD_WRITE = 0; CMD_PROT = '0; RSP_READY = 0; MREADY = 0; MRDATA = '0;
    MSLVERR = 0; ERR_CLR = 0;
    repeat (2) nxt();
    chk("rst_mreq", MREQ, 1'b0);
    chk("rst_fill", FILL_LEVEL, 0);
    chk("rst_cmd_ready", CMD_READY, 1'b1);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    PRESET = 0; chk_en = 1;

    // single write
    nxt();
    cmd(32'h10, 1'b1); CMD_WDATA = 32'hA5A5_A5A5; CMD_STRB = 4'hF;
    nxt();
    CMD_VALID = 0;
    chk("wr_fill1", FILL_LEVEL, 1);
    chk("wr_mreq_lat", MREQ, 1'b0);
    nxt();
    chk("wr_mreq", MREQ, 1'b1);
    chk("wr_maddr", MADDR, 32'h10);
    chk("wr_mwdata", MWDATA, 32'hA5A5_A5A5);
    MREADY = 1; MRDATA = 32'hDEAD_BEEF;
    nxt();
    MREADY = 0;
    chk("wr_rsp_valid", RSP_VALID, 1'b1);
    chk("wr_rsp_rdata", RSP_RDATA, 32'h0);
    chk("wr_mreq_drop", MREQ, 1'b0);
    RSP_READY = 1; nxt(); RSP_READY = 0;

    // single read
    cmd(32'h20, 1'b0); nxt();
    CMD_VALID = 0; nxt();
    chk("rd_mwrite", MWRITE, 1'b0);
    MREADY = 1; MRDATA = 32'h1234_5678;
    nxt();
    MREADY = 0;
    chk("rd_rsp_rdata", RSP_RDATA, 32'h1234_5678);
    chk("rd_maddr_zero", MADDR, 32'h0);
    RSP_READY = 1; nxt(); RSP_READY = 0;

    // fill and backpressure
    for (int i = 0; i < 4; i++) begin
      cmd(32'h100 + 32'(i * 4), 1'($urandom)); nxt();
    end
    chk("full_ready", CMD_READY, 1'b0);
    chk("full_fill", FILL_LEVEL, 4);
    cmd(32'h200, 1'b1); nxt(); nxt();
    chk("full_hold", FILL_LEVEL, 4);
    MREADY = 1; MRDATA = $urandom; nxt();
    MREADY = 0;
    chk("full_pop_no_push", FILL_LEVEL, 3);
    nxt();
    CMD_VALID = 0;
    chk("full_fifth", FILL_LEVEL, 4);
    RSP_READY = 1; MREADY = 1;
    repeat (12) nxt();
    RSP_READY = 0; MREADY = 0;
    chk("drain_fill", FILL_LEVEL, 0);

    // response stall
    cmd(32'h300, 1'b0); nxt();
    cmd(32'h304, 1'b1); nxt();
    CMD_VALID = 0;
    MREADY = 1; MRDATA = 32'hCAFE_0001; nxt();
    MREADY = 0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_mreq", MREQ, 1'b0);
      chk("stall_rdata", RSP_RDATA, 32'hCAFE_0001);
      nxt();
    end
    RSP_READY = 1; nxt(); RSP_READY = 0;
    chk("stall_mreq2", MREQ, 1'b1);
    chk("stall_maddr2", MADDR, 32'h304);
    MREADY = 1; nxt(); MREADY = 0; RSP_READY = 1; nxt(); RSP_READY = 0;

    // reset mid-issue
    for (int i = 0; i < 3; i++) begin
      cmd(32'h400 + 32'(i), 1'b1); nxt();
    end
    CMD_VALID = 0;
    chk("mid_mreq", MREQ, 1'b1);
    chk("mid_fill", FILL_LEVEL, 3);
    PRESET = 1; nxt(); PRESET = 0;
    chk("mid_rst_mreq", MREQ, 1'b0);
    chk("mid_rst_fill", FILL_LEVEL, 0);
    chk("mid_rst_maddr", MADDR, 32'h0);
    chk("mid_rst_ready", CMD_READY, 1'b1);

`ifdef APB_REQ_ERRCNT_EN
    for (int i = 0; i < 3; i++) xfer(32'h500 + 32'(i), 1'b1, 1'b0);
    chk("errcnt3", ERR_CNT, 16'd3);
    xfer(32'h510, 1'b1, 1'b1);
    chk("errcnt_clr", ERR_CNT, 16'd0);
`else
    xfer(32'h500, 1'b1, 1'b0);
    chk("slverr_capture_cleared", RSP_SLVERR, 1'b1);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      CMD_VALID = ($urandom_range(0, 1) == 1);
      CMD_ADDR = $urandom; CMD_WDATA = $urandom; CMD_STRB = SW'($urandom);
      CMD_WRITE = 1'($urandom); CMD_PROT = PRW'($urandom);
      MREADY = ($urandom_range(0, 9) < 4);
      MRDATA = $urandom; MSLVERR = 1'($urandom);
      RSP_READY = ($urandom_range(0, 1) == 1);
      ERR_CLR = ($urandom_range(0, 49) == 0);
      PRESET = ($urandom_range(0, 199) == 0);
      nxt();
    end
    PRESET = 0; CMD_VALID = 0; MREADY = 0; RSP_READY = 0; ERR_CLR = 0;
    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
